// File: rtl/usadd7_accum.sv
// Unary-sum scaler: accumulates parallel-count inputs and emits one output bit
// per valid cycle, dividing by SCALE; reports ones per 2^LENW-cycle window.
module usadd7_accum #(
  parameter int unsigned CW    = 3,
  parameter int unsigned SCALE = 7,
  parameter int unsigned LENW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [CW-1:0]   in_cnt,
  output logic            out_valid,
  output logic            out_bit,
  output logic            win_done,
  output logic [LENW:0]   win_ones
);

  localparam int unsigned AW = $clog2(2 * SCALE);

  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_nxt;
  logic            bit_d;
  logic            last;
  logic [LENW-1:0] wcnt;
  logic [LENW:0]   ones;
  logic [LENW:0]   ones_nxt;

  // acc_q stays below SCALE and in_cnt never exceeds SCALE, so sum fits in AW bits
  always_comb begin
    sum      = acc_q + AW'(in_cnt);
    bit_d    = (sum >= AW'(SCALE));
    acc_nxt  = bit_d ? (sum - AW'(SCALE)) : sum;
    last     = (wcnt == '1);
    ones_nxt = ones + (LENW+1)'(bit_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      wcnt      <= '0;
      ones      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      win_done  <= 1'b0;
      win_ones  <= '0;
    end else if (clr) begin
      acc_q     <= '0;
      wcnt      <= '0;
      ones      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      win_done  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_bit   <= bit_d;
      wcnt      <= wcnt + 1'b1;
      if (last) begin
        // residue is dropped so each window's count stands on its own
        win_done <= 1'b1;
        win_ones <= ones_nxt;
        ones     <= '0;
        acc_q    <= '0;
      end else begin
        win_done <= 1'b0;
        ones     <= ones_nxt;
        acc_q    <= acc_nxt;
      end
    end else begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      win_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usadd7_accum.sv
// Directed bench for usadd7_accum: constant-count windows, gaps, clear and
// asynchronous reset, checked against closed-form expected bit patterns.
module tb_usadd7_accum;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [2:0] in_cnt;
  logic       out_valid;
  logic       out_bit;
  logic       win_done;
  logic [8:0] win_ones;

  int checks = 0;
  int errors = 0;
  int widx = 0;       // valid cycles seen in the current window
  int last_ones = 0;  // win_ones value expected to be held
  int ones_seen = 0;

  usadd7_accum #(.CW(3), .SCALE(7), .LENW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_bit(out_bit), .win_done(win_done), .win_ones(win_ones)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; window position i gives bit = floor(c*i/7)-floor(c*(i-1)/7)
  task automatic step(input bit v, input int c, input string tag);
    int  i;
    bit  eb;
    bit  ed;
    @(negedge clk);
    in_valid = v;
    in_cnt   = 3'(c);
    @(posedge clk);
    #1;
    eb = 1'b0;
    ed = 1'b0;
    if (v) begin
      widx++;
      i  = widx;
      eb = ((c * i) / 7) != ((c * (i - 1)) / 7);
      ed = (i == 256);
    end
    if (eb) ones_seen++;
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_bit"},   32'(out_bit),   32'(eb));
    chk({tag, "_done"},  32'(win_done),  32'(ed));
    if (ed) begin
      last_ones = (c * 256) / 7;
      chk({tag, "_ones"}, 32'(win_ones), 32'(last_ones));
      widx = 0;
    end else begin
      chk({tag, "_hold"}, 32'(win_ones), 32'(last_ones));
    end
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_cnt = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_bit",   32'(out_bit),   0);
    chk("rst_done",  32'(win_done),  0);
    chk("rst_ones",  32'(win_ones),  0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // all-zero input: two windows, no ones
    for (int k = 0; k < 512; k++) step(1'b1, 0, "zero");

    // full-scale input: every bit is 1
    ones_seen = 0;
    for (int k = 0; k < 256; k++) step(1'b1, 7, "seven");
    chk("seven_total", 32'(ones_seen), 256);

    // minimum input: ones on cycles 7,14,...,252
    ones_seen = 0;
    for (int k = 0; k < 256; k++) step(1'b1, 1, "one");
    chk("one_total", 32'(ones_seen), 36);

    // cnt=3 gap-free, then the same with random gaps
    ones_seen = 0;
    for (int k = 0; k < 256; k++) step(1'b1, 3, "three");
    chk("three_total", 32'(ones_seen), 109);
    ones_seen = 0;
    for (int k = 0; k < 256; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1'b0, 5, "gap_idle");
      end
      step(1'b1, 3, "gap");
    end
    chk("gap_total", 32'(ones_seen), 109);

    // partial window at 6, then clear together with a valid input
    for (int k = 0; k < 100; k++) step(1'b1, 6, "six");
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_cnt = 3'd7;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_bit",   32'(out_bit),   0);
    chk("clr_done",  32'(win_done),  0);
    chk("clr_ones",  32'(win_ones),  32'(last_ones));
    widx = 0;
    for (int k = 0; k < 256; k++) step(1'b1, 7, "post_clr");

    // asynchronous reset between edges while out_bit is high
    for (int k = 0; k < 7; k++) step(1'b1, 1, "pre_rst");
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_bit",   32'(out_bit),   0);
    chk("arst_done",  32'(win_done),  0);
    chk("arst_ones",  32'(win_ones),  0);
    last_ones = 0;
    widx = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ones_seen = 0;
    for (int k = 0; k < 256; k++) step(1'b1, 1, "post_rst");
    chk("post_rst_total", 32'(ones_seen), 36);

    step(1'b0, 0, "idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usadd7_accum.md
USADD7_ACCUM -- requirements
Module: usadd7_accum

Interface
REQ-001 Parameter CW, default 3: width of the parallel-count input (count of up to 2^CW-1 unary ones per cycle).
REQ-002 Parameter SCALE, default 7: scaling divisor (number of summed unary streams); SCALE >= 2^CW-1 SHALL hold.
REQ-003 Parameter LENW, default 8: window length is 2^LENW valid cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear of accumulator, window counter and ones counter.
REQ-007 in_valid  input  1  in_cnt is valid this cycle.
REQ-008 in_cnt  input  CW  number of ones among the 7 input bitstreams this cycle (upstream parallel counter output).
REQ-009 out_valid  output  1  out_bit is valid (registered).
REQ-010 out_bit  output  1  scaled-sum output bitstream bit.
REQ-011 win_done  output  1  one-cycle pulse at end of each window.
REQ-012 win_ones  output  LENW+1  number of ones emitted in the window just completed; held until next win_done.

Function
REQ-013 Internal accumulator acc_q SHALL be ceil(log2(2*SCALE)) bits (4 for defaults), range 0..SCALE-1 between updates.
REQ-014 On a cycle with in_valid=1 and clr=0: s = acc_q + in_cnt; if s >= SCALE then out_bit<=1, acc_q<=s-SCALE; else out_bit<=0, acc_q<=s.
REQ-015 out_valid SHALL equal in_valid delayed by exactly one cycle; latency input->out_bit is 1 cycle.
REQ-016 When in_valid=0: acc_q, window counter and ones counter hold; out_valid<=0; out_bit<=0.
REQ-017 Window counter wcnt (LENW bits) SHALL increment on each valid cycle and wrap from 2^LENW-1 to 0.
REQ-018 Ones counter SHALL add the bit produced on each valid cycle.
REQ-019 On the valid cycle with wcnt=2^LENW-1: win_done<=1 next cycle, win_ones<=ones count including that cycle's bit, ones counter<=0, acc_q<=0 (residue discarded; windows independent).
REQ-020 win_done SHALL be 1 for exactly one cycle per window, aligned with out_valid of the final bit.
REQ-021 clr=1 SHALL take priority over in_valid: acc_q, wcnt, ones counter<=0; out_valid<=0, out_bit<=0, win_done<=0; win_ones holds; in_cnt that cycle is dropped.
REQ-022 Gaps in in_valid SHALL not affect results: output sequence depends only on the sequence of valid in_cnt values.
REQ-023 Total ones per full window SHALL equal floor(sum of in_cnt over window / SCALE).

Reset
REQ-024 rst_n=0 SHALL immediately clear acc_q, wcnt, ones counter, out_valid, out_bit, win_done and win_ones to 0 regardless of clk.
REQ-025 Reset mid-window SHALL discard the partial window; first valid cycle after release starts a new window at wcnt=0.
REQ-026 rst_n deassertion SHALL be synchronised externally; block assumes release meets recovery timing.

Verification
REQ-027 in_cnt=7 constant, 256 valid cycles -> out_bit=1 every valid cycle, one win_done, win_ones=256.
REQ-028 in_cnt=1 constant, 256 valid cycles -> out_bit=1 on valid cycles 7,14,...,252, win_ones=36.
REQ-029 in_cnt=3 constant, 256 valid cycles with random in_valid gaps -> bit pattern identical to gap-free run, win_ones=109.
REQ-030 in_cnt=0 constant, 512 valid cycles -> out_bit always 0, two win_done pulses each with win_ones=0.
REQ-031 in_cnt=6 for 100 valid cycles, clr=1 together with in_valid=1, then in_cnt=7 for 256 cycles -> first output after clr has out_valid 1 cycle after next valid, win_done after 256 more valid cycles with win_ones=256, win_ones unchanged by clr.
REQ-032 rst_n pulsed low asynchronously mid-window (between edges) -> all outputs 0 immediately; subsequent in_cnt=1 run gives first out_bit=1 on 7th valid cycle.
